// File: rtl/mc_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath:
// opcode/memory handshake in, strobes and mux selects out.
interface mc_main_fsm_if;
    logic [6:0] op;
    logic       mem_ready;
    logic       pcupdate;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       illegal;

    modport master (
        output op, mem_ready,
        input  pcupdate, irwrite, regwrite, memwrite, branch, adrsrc,
        input  resultsrc, alusrca, alusrcb, aluop, illegal
    );

    modport slave (
        input  op, mem_ready,
        output pcupdate, irwrite, regwrite, memwrite, branch, adrsrc,
        output resultsrc, alusrca, alusrcb, aluop, illegal
    );
endinterface

// File: rtl/mc_main_fsm.sv
// Multicycle RISC-V main control FSM: Moore-decoded datapath strobes,
// optional memory wait states, illegal-opcode trap and retired counter.
module mc_main_fsm #(
    parameter bit WAIT_MEM = 1'b1,
    parameter bit EN_JAL   = 1'b1,
    parameter bit EN_BEQ   = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_main_fsm_if.slave     bus,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        JAL      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             mem_ok;
    logic             retire;

    // Without wait states every memory access completes in its first cycle.
    assign mem_ok = WAIT_MEM ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        bus.pcupdate  = 1'b0;
        bus.irwrite   = 1'b0;
        bus.regwrite  = 1'b0;
        bus.memwrite  = 1'b0;
        bus.branch    = 1'b0;
        bus.adrsrc    = 1'b0;
        bus.resultsrc = 2'b00;
        bus.alusrca   = 2'b00;
        bus.alusrcb   = 2'b00;
        bus.aluop     = 2'b00;
        bus.illegal   = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // Gate the IR/PC strobes so a stalled fetch loads exactly once.
                bus.irwrite   = mem_ok;
                bus.pcupdate  = mem_ok;
                bus.alusrcb   = 2'b10;
                bus.resultsrc = 2'b10;
                if (mem_ok) state_d = DECODE;
            end
            DECODE: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = EN_JAL ? JAL : TRAP;
                    OP_BEQ:       state_d = EN_BEQ ? BEQ : TRAP;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                state_d     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.adrsrc = 1'b1;
                if (mem_ok) state_d = MEMWB;
            end
            MEMWB: begin
                bus.resultsrc = 2'b01;
                bus.regwrite  = 1'b1;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                // Write strobe is held for the whole wait, not gated by mem_ready.
                bus.adrsrc   = 1'b1;
                bus.memwrite = 1'b1;
                if (mem_ok) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECR: begin
                bus.alusrca = 2'b10;
                bus.aluop   = 2'b10;
                state_d     = ALUWB;
            end
            EXECI: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                bus.aluop   = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.regwrite = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            BEQ: begin
                bus.alusrca = 2'b10;
                bus.aluop   = 2'b01;
                bus.branch  = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            JAL: begin
                bus.alusrca  = 2'b01;
                bus.alusrcb  = 2'b10;
                bus.pcupdate = 1'b1;
                state_d      = ALUWB;
            end
            TRAP: begin
                bus.illegal = 1'b1;
                state_d     = TRAP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm: three parameterisations share clk/rst_n.
module tb_mc_main_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instret0, instret2;
    logic [3:0]  instret1;
    logic [3:0]  st0, st1, st2;
    int          errors = 0;
    int          checks = 0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    mc_main_fsm_if b0 ();
    mc_main_fsm_if b1 ();
    mc_main_fsm_if b2 ();

    // u0: defaults; u1: no wait states, no jal, 4-bit counter; u2: no beq.
    mc_main_fsm #(.WAIT_MEM(1'b1), .EN_JAL(1'b1), .EN_BEQ(1'b1), .CNT_W(32)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .instret(instret0), .state_dbg(st0));
    mc_main_fsm #(.WAIT_MEM(1'b0), .EN_JAL(1'b0), .EN_BEQ(1'b1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .instret(instret1), .state_dbg(st1));
    mc_main_fsm #(.WAIT_MEM(1'b1), .EN_JAL(1'b1), .EN_BEQ(1'b0), .CNT_W(32)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2), .instret(instret2), .state_dbg(st2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        b0.op = OP_LW; b0.mem_ready = 1'b0;
        b1.op = OP_LW; b1.mem_ready = 1'b0;
        b2.op = OP_LW; b2.mem_ready = 1'b0;
        #3;
        checks++;
        if ({b0.pcupdate, b0.irwrite, b0.regwrite, b0.memwrite, b0.branch, b0.adrsrc,
             b0.resultsrc, b0.alusrca, b0.alusrcb, b0.aluop, b0.illegal, st0, instret0} !== '0) begin
            errors++; $display("FAIL reset_u0_outputs: st=%0d instret=%0d", st0, instret0);
        end
        checks++;
        if ({st1, instret1} !== 8'h00) begin
            errors++; $display("FAIL reset_u1: st=%0d instret=%0d required 0/0", st1, instret1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (st0 !== 4'd1 || b0.irwrite !== 1'b0) begin
            errors++; $display("FAIL reset_first_fetch: st=%0d irwrite=%b required 1/0", st0, b0.irwrite);
        end
        b0.mem_ready = 1'b1;
        #1;
        checks++;
        if (b0.irwrite !== 1'b1 || b0.pcupdate !== 1'b1) begin
            errors++; $display("FAIL fetch_ready_strobe: irwrite=%b pcupdate=%b required 1/1", b0.irwrite, b0.pcupdate);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (st0 !== 4'd0 || b0.irwrite !== 1'b0 || b0.pcupdate !== 1'b0) begin
            errors++; $display("FAIL reset_async: st=%0d irwrite=%b required 0/0", st0, b0.irwrite);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        int exp_st[7];
        logic exp_rw[7];
        exp_st = '{0, 1, 2, 3, 4, 5, 1};
        exp_rw = '{0, 0, 0, 0, 0, 1, 0};
        b0.op = OP_LW; b0.mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (st0 !== 4'(exp_st[i]) || b0.regwrite !== exp_rw[i]) begin
                errors++; $display("FAIL lw_seq[%0d]: st=%0d regwrite=%b required %0d/%b",
                                   i, st0, b0.regwrite, exp_st[i], exp_rw[i]);
            end
        end
        checks++;
        if (instret0 !== 32'd1) begin
            errors++; $display("FAIL lw_instret: got %0d required 1", instret0);
        end
    endtask

    task automatic test_sw_wait();
        int mw_cycles = 0;
        b0.op = OP_SW; b0.mem_ready = 1'b1;
        do_reset();
        tick(); tick(); tick();
        checks++;
        if (st0 !== 4'd3 || b0.alusrca !== 2'b10 || b0.alusrcb !== 2'b01) begin
            errors++; $display("FAIL sw_memadr: st=%0d alusrca=%b alusrcb=%b required 3/10/01", st0, b0.alusrca, b0.alusrcb);
        end
        b0.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            b0.mem_ready = (i == 3);
            #1;
            if (st0 == 4'd6 && b0.memwrite === 1'b1 && b0.adrsrc === 1'b1) mw_cycles++;
            checks++;
            if (instret0 !== 32'd0) begin
                errors++; $display("FAIL sw_early_retire[%0d]: instret=%0d required 0", i, instret0);
            end
            tick();
        end
        checks++;
        if (mw_cycles != 4) begin
            errors++; $display("FAIL sw_memwrite_len: got %0d cycles required 4", mw_cycles);
        end
        checks++;
        if (st0 !== 4'd1 || b0.memwrite !== 1'b0 || instret0 !== 32'd1) begin
            errors++; $display("FAIL sw_done: st=%0d memwrite=%b instret=%0d required 1/0/1", st0, b0.memwrite, instret0);
        end
    endtask

    task automatic test_fetch_wait();
        int pulses = 0;
        b0.op = OP_R; b0.mem_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            b0.mem_ready = (i == 2);
            #1;
            if (b0.irwrite === 1'b1 && b0.pcupdate === 1'b1) pulses++;
            checks++;
            if (st0 !== 4'd1 || b0.irwrite !== (i == 2)) begin
                errors++; $display("FAIL fetch_wait[%0d]: st=%0d irwrite=%b required 1/%b", i, st0, b0.irwrite, (i == 2));
            end
            tick();
        end
        checks++;
        if (pulses != 1 || st0 !== 4'd2 || b0.irwrite !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse: pulses=%0d st=%0d required 1/2", pulses, st0);
        end
        tick();
        checks++;
        if (st0 !== 4'd7 || b0.aluop !== 2'b10 || b0.alusrca !== 2'b10 || b0.alusrcb !== 2'b00) begin
            errors++; $display("FAIL execr: st=%0d aluop=%b alusrca=%b required 7/10/10", st0, b0.aluop, b0.alusrca);
        end
        tick();
        checks++;
        if (st0 !== 4'd9 || b0.regwrite !== 1'b1) begin
            errors++; $display("FAIL r_aluwb: st=%0d regwrite=%b required 9/1", st0, b0.regwrite);
        end
        tick();
        checks++;
        if (st0 !== 4'd1 || instret0 !== 32'd1) begin
            errors++; $display("FAIL r_retire: st=%0d instret=%0d required 1/1", st0, instret0);
        end
    endtask

    task automatic test_jal_trap();
        b0.op = OP_JAL; b0.mem_ready = 1'b1;
        b1.op = OP_JAL; b1.mem_ready = 1'b0;
        do_reset();
        tick();
        checks++;
        if (st1 !== 4'd1 || b1.irwrite !== 1'b1) begin
            errors++; $display("FAIL nowait_fetch: st=%0d irwrite=%b required 1/1", st1, b1.irwrite);
        end
        tick(); tick();
        checks++;
        if (st1 !== 4'd12 || b1.illegal !== 1'b1) begin
            errors++; $display("FAIL jal_trap: st=%0d illegal=%b required 12/1", st1, b1.illegal);
        end
        checks++;
        if (st0 !== 4'd11 || b0.pcupdate !== 1'b1 || b0.alusrca !== 2'b01 || b0.alusrcb !== 2'b10) begin
            errors++; $display("FAIL jal_state: st=%0d pcupdate=%b alusrca=%b alusrcb=%b required 11/1/01/10",
                               st0, b0.pcupdate, b0.alusrca, b0.alusrcb);
        end
        tick(); tick();
        checks++;
        if (st0 !== 4'd1 || instret0 !== 32'd1) begin
            errors++; $display("FAIL jal_retire: st=%0d instret=%0d required 1/1", st0, instret0);
        end
        tick(); tick();
        checks++;
        if (st1 !== 4'd12 || b1.illegal !== 1'b1 || instret1 !== 4'd0) begin
            errors++; $display("FAIL trap_sticky: st=%0d illegal=%b instret=%0d required 12/1/0", st1, b1.illegal, instret1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (st1 !== 4'd0 || b1.illegal !== 1'b0) begin
            errors++; $display("FAIL trap_reset: st=%0d illegal=%b required 0/0", st1, b1.illegal);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_beq_wrap();
        b0.op = OP_BEQ; b0.mem_ready = 1'b1;
        b1.op = OP_BEQ; b1.mem_ready = 1'b0;
        b2.op = OP_BEQ; b2.mem_ready = 1'b1;
        do_reset();
        tick(); tick(); tick();
        checks++;
        if (st1 !== 4'd10 || b1.branch !== 1'b1 || b1.aluop !== 2'b01 || b1.alusrca !== 2'b10) begin
            errors++; $display("FAIL beq_state: st=%0d branch=%b aluop=%b required 10/1/01", st1, b1.branch, b1.aluop);
        end
        checks++;
        if (st2 !== 4'd12 || b2.illegal !== 1'b1) begin
            errors++; $display("FAIL beq_disabled: st=%0d illegal=%b required 12/1", st2, b2.illegal);
        end
        for (int i = 0; i < 42; i++) tick();
        checks++;
        if (st1 !== 4'd10 || instret1 !== 4'd14) begin
            errors++; $display("FAIL beq_count14: st=%0d instret=%0d required 10/14", st1, instret1);
        end
        tick();
        checks++;
        if (st1 !== 4'd1 || instret1 !== 4'd15) begin
            errors++; $display("FAIL beq_count15: st=%0d instret=%0d required 1/15", st1, instret1);
        end
        tick(); tick(); tick();
        checks++;
        if (st1 !== 4'd1 || instret1 !== 4'd0) begin
            errors++; $display("FAIL beq_wrap: st=%0d instret=%0d required 1/0", st1, instret1);
        end
        checks++;
        if (instret0 !== 32'd16 || instret2 !== 32'd0) begin
            errors++; $display("FAIL beq_u0_u2: instret0=%0d instret2=%0d required 16/0", instret0, instret2);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[3];
        int lens[3];
        int exp_st[13];
        int k = 0;
        ops    = '{OP_LW, OP_SW, OP_I};
        lens   = '{5, 4, 4};
        exp_st = '{2, 3, 4, 5, 1,  2, 3, 6, 1,  2, 8, 9, 1};
        b1.op = OP_LW; b1.mem_ready = 1'b0;
        do_reset();
        tick();
        for (int n = 0; n < 3; n++) begin
            b1.op = ops[n];
            for (int c = 0; c < lens[n]; c++) begin
                tick();
                checks++;
                if (st1 !== 4'(exp_st[k]) || b1.memwrite !== (exp_st[k] == 6) ||
                    b1.regwrite !== (exp_st[k] == 5 || exp_st[k] == 9)) begin
                    errors++; $display("FAIL b2b[%0d]: st=%0d memwrite=%b regwrite=%b required st %0d",
                                       k, st1, b1.memwrite, b1.regwrite, exp_st[k]);
                end
                k++;
            end
        end
        checks++;
        if (instret1 !== 4'd3) begin
            errors++; $display("FAIL b2b_instret: got %0d required 3", instret1);
        end
    endtask

    task automatic test_reset_mid();
        b0.op = OP_I; b0.mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        b0.op = OP_LW;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (st0 !== 4'd5 || b0.regwrite !== 1'b1 || instret0 !== 32'd1) begin
            errors++; $display("FAIL mid_memwb: st=%0d regwrite=%b instret=%0d required 5/1/1", st0, b0.regwrite, instret0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (st0 !== 4'd0 || b0.regwrite !== 1'b0 || instret0 !== 32'd0) begin
            errors++; $display("FAIL mid_memwb_reset: st=%0d regwrite=%b instret=%0d required 0/0/0", st0, b0.regwrite, instret0);
        end
        rst_n = 1'b1;
        b0.op = OP_SW;
        tick(); tick(); tick();
        b0.mem_ready = 1'b0;
        tick(); tick();
        checks++;
        if (st0 !== 4'd6 || b0.memwrite !== 1'b1) begin
            errors++; $display("FAIL mid_memwrite_wait: st=%0d memwrite=%b required 6/1", st0, b0.memwrite);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b0.memwrite !== 1'b0 || b0.adrsrc !== 1'b0 || st0 !== 4'd0) begin
            errors++; $display("FAIL mid_memwrite_reset: memwrite=%b adrsrc=%b st=%0d required 0/0/0", b0.memwrite, b0.adrsrc, st0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (st0 !== 4'd1) begin
            errors++; $display("FAIL mid_release_fetch: st=%0d required 1", st0);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait();
        test_jal_trap();
        test_beq_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 Parameter WAIT_MEM, default 1, meaning: 1 = stall in memory states until mem_ready is high; 0 = memory always single-cycle, mem_ready ignored.
REQ-002 Parameter EN_JAL, default 1, meaning: 1 = jal (op 1101111) supported; 0 = jal treated as illegal.
REQ-003 Parameter EN_BEQ, default 1, meaning: 1 = beq (op 1100011) supported; 0 = beq treated as illegal.
REQ-004 Parameter CNT_W, default 32, meaning: width of retired-instruction counter.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 op  input  7  opcode from instruction register; stable from DECODE until return to FETCH.
REQ-009 mem_ready  input  1  memory access completes this cycle.
REQ-010 pcupdate, irwrite, regwrite, memwrite, branch, adrsrc  output  1 each  datapath strobes/selects.
REQ-011 resultsrc, alusrca, alusrcb, aluop  output  2 each  datapath mux selects and ALU-decoder class.
REQ-012 illegal  output  1  unsupported opcode trapped.
REQ-013 instret  output  CNT_W  retired-instruction count.
REQ-014 state_dbg  output  4  current state encoding.

Function
REQ-015 States and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BEQ=10, JAL=11, TRAP=12.
REQ-016 Outputs SHALL be Moore-decoded from state (except mem_ready gating per REQ-019); any field not listed for a state SHALL be 0.
REQ-017 Per-state outputs: FETCH irwrite=1 pcupdate=1 alusrcb=10 resultsrc=10; DECODE alusrca=01 alusrcb=01; MEMADR alusrca=10 alusrcb=01; MEMREAD adrsrc=1; MEMWB resultsrc=01 regwrite=1; MEMWRITE adrsrc=1 memwrite=1; EXECR alusrca=10 aluop=10; EXECI alusrca=10 alusrcb=01 aluop=10; ALUWB regwrite=1; BEQ alusrca=10 aluop=01 branch=1; JAL alusrca=01 alusrcb=10 pcupdate=1; TRAP illegal=1.
REQ-018 Transitions: IDLE->FETCH unconditionally; FETCH->DECODE; DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL (EN_JAL=1), 1100011->BEQ (EN_BEQ=1), otherwise->TRAP; MEMADR: 0000011->MEMREAD, else->MEMWRITE; MEMREAD->MEMWB; MEMWB->FETCH; MEMWRITE->FETCH; EXECR/EXECI/JAL->ALUWB; ALUWB->FETCH; BEQ->FETCH; TRAP->TRAP.
REQ-019 With WAIT_MEM=1, FETCH, MEMREAD and MEMWRITE SHALL hold until mem_ready=1; in FETCH irwrite and pcupdate SHALL be asserted only in the cycle mem_ready=1 (exactly one pulse per fetch); memwrite and adrsrc SHALL remain asserted throughout the MEMWRITE wait.
REQ-020 With WAIT_MEM=0, each of FETCH, MEMREAD and MEMWRITE SHALL last exactly one cycle, with strobes ungated.
REQ-021 Cycles per instruction with zero wait states: lw 5, sw 4, R/I-type 4, jal 4, beq 3.
REQ-022 instret SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ, and SHALL wrap from all-ones to 0.
REQ-023 TRAP SHALL be sticky until rst_n is asserted; instret SHALL NOT increment for a trapped instruction.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, instret=0, and all outputs to 0, independent of clk.
REQ-025 Assertion of rst_n mid-instruction (including a MEMWRITE wait) SHALL drop memwrite and regwrite in the same cycle; after release, the first clk edge SHALL enter FETCH.

Verification
REQ-026 Reset release, WAIT_MEM=1, mem_ready=1, op=0000011 -> state_dbg 0,1,2,3,4,5,1; regwrite high only in state 5; instret=1.
REQ-027 op=0100011 with mem_ready low for 3 cycles in MEMWRITE -> memwrite high for 4 cycles; exactly one instret increment.
REQ-028 FETCH with mem_ready low for 2 cycles -> irwrite/pcupdate single pulse on the third cycle; DECODE follows.
REQ-029 EN_JAL=0, op=1101111 -> DECODE->TRAP, illegal=1 held, instret unchanged; rst_n pulse -> IDLE, illegal=0.
REQ-030 CNT_W=4: 16 back-to-back beq instructions -> instret wraps 15->0.
REQ-031 rst_n asserted during MEMWB -> regwrite=0 in the same cycle, instret=0.
